demux11: RTL and testbench

Registered 1-to-11 write-side demultiplexer: the counterpart of the 11-input source mux feeding the datapath bus. A single 32-bit producer value is steered by a 4-bit `controle` code into one of 11 holding registers. Each register has its own `valido` flag, raised on write and cleared by the destination's `consome` acknowledge. Sticky error flags report illegal codes and unconsumed overwrites to the control unit.

---
 rtl/demux11.sv | 88 ++++++++
 tb/tb_demux11.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux11.sv
// Registered 1-to-11 write-side demultiplexer: steers one producer word into
// one of eleven holding registers, with per-channel valid flags and sticky error reporting.
module demux11 #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] entrada,
    input  logic [3:0]         controle,
    input  logic               escreve,
    input  logic [10:0]        consome,
    input  logic               limpa_erros,
    output logic [LARGURA-1:0] saida0,
    output logic [LARGURA-1:0] saida1,
    output logic [LARGURA-1:0] saida2,
    output logic [LARGURA-1:0] saida3,
    output logic [LARGURA-1:0] saida4,
    output logic [LARGURA-1:0] saida5,
    output logic [LARGURA-1:0] saida6,
    output logic [LARGURA-1:0] saida7,
    output logic [LARGURA-1:0] saida8,
    output logic [LARGURA-1:0] saida9,
    output logic [LARGURA-1:0] saida10,
    output logic [10:0]        valido,
    output logic [3:0]         ocupacao,
    output logic               erro_controle,
    output logic               sobrescrita
);

    logic [LARGURA-1:0] regs [11];
    logic               wr_legal;
    logic               wr_ilegal;
    logic               ovw;
    logic [10:0]        wr_sel;
    logic [10:0]        valido_next;
    logic [3:0]         cnt_next;

    always_comb begin
        wr_legal    = escreve && (controle <= 4'd10);
        wr_ilegal   = escreve && (controle > 4'd10);
        wr_sel      = wr_legal ? (11'd1 << controle) : '0;
        // A write on a channel being consumed in the same cycle is not an overwrite.
        valido_next = (valido & ~consome) | wr_sel;
        ovw         = |(wr_sel & valido & ~consome);
        cnt_next    = '0;
        for (int unsigned i = 0; i < 11; i++) begin
            cnt_next = cnt_next + 4'(valido_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < 11; i++) begin
            if (!reset) begin
                regs[i] <= '0;
            end else if (wr_sel[i]) begin
                regs[i] <= entrada;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valido        <= '0;
            ocupacao      <= '0;
            erro_controle <= 1'b0;
            sobrescrita   <= 1'b0;
        end else begin
            valido        <= valido_next;
            ocupacao      <= cnt_next;
            // Set has priority over clear.
            erro_controle <= wr_ilegal | (erro_controle & ~limpa_erros);
            sobrescrita   <= ovw | (sobrescrita & ~limpa_erros);
        end
    end

    assign saida0  = regs[0];
    assign saida1  = regs[1];
    assign saida2  = regs[2];
    assign saida3  = regs[3];
    assign saida4  = regs[4];
    assign saida5  = regs[5];
    assign saida6  = regs[6];
    assign saida7  = regs[7];
    assign saida8  = regs[8];
    assign saida9  = regs[9];
    assign saida10 = regs[10];

endmodule

// File: tb/tb_demux11.sv
// Self-checking bench for demux11: directed scenarios plus randomized traffic
// compared against a behavioural model of the channel/flag rules.
module tb_demux11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] entrada = '0;
    logic [3:0]  controle = '0;
    logic        escreve = 1'b0;
    logic [10:0] consome = '0;
    logic        limpa_erros = 1'b0;
    logic [31:0] saida0, saida1, saida2, saida3, saida4, saida5;
    logic [31:0] saida6, saida7, saida8, saida9, saida10;
    logic [10:0] valido;
    logic [3:0]  ocupacao;
    logic        erro_controle;
    logic        sobrescrita;

    logic [31:0] sa [11];

    logic [31:0] md [11];
    logic [10:0] mv;
    logic        merr;
    logic        mso;

    int total = 0;
    int bad = 0;

    demux11 #(.LARGURA(32)) dut (
        .clock(clock), .reset(reset), .entrada(entrada), .controle(controle),
        .escreve(escreve), .consome(consome), .limpa_erros(limpa_erros),
        .saida0(saida0), .saida1(saida1), .saida2(saida2), .saida3(saida3),
        .saida4(saida4), .saida5(saida5), .saida6(saida6), .saida7(saida7),
        .saida8(saida8), .saida9(saida9), .saida10(saida10),
        .valido(valido), .ocupacao(ocupacao),
        .erro_controle(erro_controle), .sobrescrita(sobrescrita)
    );

    assign sa[0] = saida0;  assign sa[1] = saida1;  assign sa[2]  = saida2;
    assign sa[3] = saida3;  assign sa[4] = saida4;  assign sa[5]  = saida5;
    assign sa[6] = saida6;  assign sa[7] = saida7;  assign sa[8]  = saida8;
    assign sa[9] = saida9;  assign sa[10] = saida10;

    always #5 clock = ~clock;

    // Drive one cycle of inputs, advance the model by the behavioural rules, sample 1 after the edge.
    task automatic apply(input logic r, input logic w, input logic [3:0] c,
                         input logic [31:0] d, input logic [10:0] cons, input logic lim);
        logic legal;
        logic ovw;
        @(negedge clock);
        reset = r; escreve = w; controle = c; entrada = d; consome = cons; limpa_erros = lim;
        @(posedge clock);
        if (!r) begin
            for (int k = 0; k < 11; k++) md[k] = '0;
            mv = '0; merr = 1'b0; mso = 1'b0;
        end else begin
            legal = w && (c < 11);
            ovw = legal && mv[c] && !cons[c];
            for (int k = 0; k < 11; k++) if (cons[k]) mv[k] = 1'b0;
            if (legal) begin
                md[c] = d;
                mv[c] = 1'b1;
            end
            merr = (w && (c >= 11)) || (merr && !lim);
            mso = ovw || (mso && !lim);
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b1, 4'd2, 32'h1234_5678, 11'h000, 1'b0);
        for (int k = 0; k < 11; k++) begin
            total++;
            if (sa[k] !== 32'h0) begin
                bad++; $display("FAIL reset_saida%0d: got %h expected 0", k, sa[k]);
            end
        end
        total++;
        if ({valido, ocupacao, erro_controle, sobrescrita} !== 17'h0) begin
            bad++; $display("FAIL reset_flags: got valido=%h ocup=%0d err=%b ovw=%b expected all 0",
                            valido, ocupacao, erro_controle, sobrescrita);
        end
    endtask

    task automatic test_write();
        apply(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 11'h000, 1'b0);
        total++;
        if (saida3 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL write_saida3: got %h expected deadbeef", saida3);
        end
        total++;
        if (valido !== 11'h008 || ocupacao !== 4'd1) begin
            bad++; $display("FAIL write_valido: got %h/%0d expected 008/1", valido, ocupacao);
        end
        for (int k = 0; k < 11; k++) begin
            if (k == 3) continue;
            total++;
            if (sa[k] !== 32'h0) begin
                bad++; $display("FAIL write_other%0d: got %h expected 0", k, sa[k]);
            end
        end
    endtask

    task automatic test_consume();
        logic [10:0] expv [3];
        expv[0] = 11'h001; expv[1] = 11'h021; expv[2] = 11'h421;
        apply(1'b0, 1'b0, 4'd0, 32'h0, 11'h000, 1'b0);
        apply(1'b1, 1'b1, 4'd0, 32'hA000_0000, 11'h000, 1'b0);
        total++;
        if (valido !== expv[0] || ocupacao !== 4'd1) begin
            bad++; $display("FAIL consume_step0: got %h/%0d expected %h/1", valido, ocupacao, expv[0]);
        end
        apply(1'b1, 1'b1, 4'd5, 32'hA000_0005, 11'h000, 1'b0);
        total++;
        if (valido !== expv[1] || ocupacao !== 4'd2) begin
            bad++; $display("FAIL consume_step1: got %h/%0d expected %h/2", valido, ocupacao, expv[1]);
        end
        apply(1'b1, 1'b1, 4'd10, 32'hA000_000A, 11'h000, 1'b0);
        total++;
        if (valido !== expv[2] || ocupacao !== 4'd3) begin
            bad++; $display("FAIL consume_step2: got %h/%0d expected %h/3", valido, ocupacao, expv[2]);
        end
        apply(1'b1, 1'b0, 4'd0, 32'h0, 11'h421, 1'b0);
        total++;
        if (valido !== 11'h000 || ocupacao !== 4'd0) begin
            bad++; $display("FAIL consume_clear: got %h/%0d expected 000/0", valido, ocupacao);
        end
        total++;
        if (saida0 !== 32'hA000_0000 || saida5 !== 32'hA000_0005 || saida10 !== 32'hA000_000A) begin
            bad++; $display("FAIL consume_retain: got %h %h %h expected a0000000 a0000005 a000000a",
                            saida0, saida5, saida10);
        end
    endtask

    task automatic test_overwrite();
        apply(1'b0, 1'b0, 4'd0, 32'h0, 11'h000, 1'b0);
        apply(1'b1, 1'b1, 4'd7, 32'h1, 11'h000, 1'b0);
        total++;
        if (sobrescrita !== 1'b0) begin
            bad++; $display("FAIL ovw_first: got %b expected 0", sobrescrita);
        end
        apply(1'b1, 1'b1, 4'd7, 32'h2, 11'h000, 1'b0);
        total++;
        if (saida7 !== 32'h2 || sobrescrita !== 1'b1) begin
            bad++; $display("FAIL ovw_set: got %h/%b expected 00000002/1", saida7, sobrescrita);
        end
        apply(1'b0, 1'b0, 4'd0, 32'h0, 11'h000, 1'b0);
        apply(1'b1, 1'b1, 4'd7, 32'h1, 11'h000, 1'b0);
        apply(1'b1, 1'b1, 4'd7, 32'h2, 11'h080, 1'b0);
        total++;
        if (saida7 !== 32'h2 || sobrescrita !== 1'b0 || valido[7] !== 1'b1) begin
            bad++; $display("FAIL ovw_consumed: got %h/%b/%b expected 00000002/0/1",
                            saida7, sobrescrita, valido[7]);
        end
    endtask

    task automatic test_illegal();
        logic [10:0] v0;
        apply(1'b0, 1'b0, 4'd0, 32'h0, 11'h000, 1'b0);
        apply(1'b1, 1'b1, 4'd1, 32'h1111_1111, 11'h000, 1'b0);
        v0 = valido;
        apply(1'b1, 1'b1, 4'hB, 32'hBBBB_BBBB, 11'h000, 1'b0);
        apply(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 11'h000, 1'b0);
        total++;
        if (erro_controle !== 1'b1 || valido !== 11'h002) begin
            bad++; $display("FAIL illegal_set: got err=%b valido=%h expected 1/002", erro_controle, valido);
        end
        for (int k = 0; k < 11; k++) begin
            total++;
            if (sa[k] !== md[k]) begin
                bad++; $display("FAIL illegal_reg%0d: got %h expected %h", k, sa[k], md[k]);
            end
        end
        apply(1'b1, 1'b0, 4'd0, 32'h0, 11'h000, 1'b1);
        total++;
        if (erro_controle !== 1'b0 || valido !== v0) begin
            bad++; $display("FAIL illegal_clear: got err=%b valido=%h expected 0/%h", erro_controle, valido, v0);
        end
        apply(1'b1, 1'b1, 4'hC, 32'h0, 11'h000, 1'b1);
        total++;
        if (erro_controle !== 1'b1) begin
            bad++; $display("FAIL illegal_setwins: got %b expected 1", erro_controle);
        end
    endtask

    task automatic test_fill();
        apply(1'b0, 1'b0, 4'd0, 32'h0, 11'h000, 1'b0);
        for (int k = 0; k < 11; k++) apply(1'b1, 1'b1, 4'(k), 32'hC0DE_0000 + 32'(k), 11'h000, 1'b0);
        total++;
        if (valido !== 11'h7FF || ocupacao !== 4'd11) begin
            bad++; $display("FAIL fill_full: got %h/%0d expected 7ff/11", valido, ocupacao);
        end
        apply(1'b1, 1'b1, 4'hD, 32'h0, 11'h000, 1'b0);
        apply(1'b0, 1'b1, 4'd4, 32'h4444_4444, 11'h010, 1'b0);
        total++;
        if (valido !== 11'h0 || ocupacao !== 4'd0 || erro_controle !== 1'b0 || saida4 !== 32'h0) begin
            bad++; $display("FAIL fill_reset: got %h/%0d/%b/%h expected 0/0/0/0",
                            valido, ocupacao, erro_controle, saida4);
        end
        apply(1'b1, 1'b1, 4'd9, 32'h9999_9999, 11'h000, 1'b0);
        total++;
        if (saida9 !== 32'h9999_9999 || valido !== 11'h200) begin
            bad++; $display("FAIL fill_recovery: got %h/%h expected 99999999/200", saida9, valido);
        end
    endtask

    task automatic test_idle();
        apply(1'b0, 1'b0, 4'd0, 32'h0, 11'h000, 1'b0);
        apply(1'b1, 1'b0, 4'd0, 32'h0, 11'h7FF, 1'b0);
        for (int n = 0; n < 8; n++) apply(1'b1, 1'b0, 4'($urandom_range(0, 15)), $urandom, 11'h000, 1'b0);
        total++;
        if (valido !== 11'h0 || ocupacao !== 4'd0 || erro_controle !== 1'b0 || sobrescrita !== 1'b0) begin
            bad++; $display("FAIL idle_flags: got %h/%0d/%b/%b expected 0", valido, ocupacao,
                            erro_controle, sobrescrita);
        end
        for (int k = 0; k < 11; k++) begin
            total++;
            if (sa[k] !== 32'h0) begin
                bad++; $display("FAIL idle_reg%0d: got %h expected 0", k, sa[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] cons;
        for (int n = 0; n < 400; n++) begin
            cons = (($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'h000);
            apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), $urandom, cons, ($urandom_range(0, 9) == 0));
            for (int k = 0; k < 11; k++) begin
                total++;
                if (sa[k] !== md[k]) begin
                    bad++; $display("FAIL rand_saida%0d cyc %0d: got %h expected %h", k, n, sa[k], md[k]);
                end
            end
            total++;
            if (valido !== mv || ocupacao !== 4'($countones(mv))) begin
                bad++; $display("FAIL rand_valido cyc %0d: got %h/%0d expected %h/%0d",
                                n, valido, ocupacao, mv, $countones(mv));
            end
            total++;
            if (erro_controle !== merr || sobrescrita !== mso) begin
                bad++; $display("FAIL rand_flags cyc %0d: got %b%b expected %b%b",
                                n, erro_controle, sobrescrita, merr, mso);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 11; k++) md[k] = '0;
        mv = '0; merr = 1'b0; mso = 1'b0;
        test_reset();
        test_write();
        test_consume();
        test_overwrite();
        test_illegal();
        test_fill();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
